// File: rtl/qwac_loader.sv
// qwac_loader: byte-stream loader that assembles matrix/vector operands and commits them atomically
module qwac_loader #(
    parameter int BITS    = 16,
    parameter int MAT_R   = 8,
    parameter int MAT_C   = 4,
    parameter int TE      = 2,
    parameter int VEC_LEN = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [MAT_R*MAT_C*BITS-1:0]    mat_flat,
    output logic [TE*VEC_LEN*BITS-1:0]     vecs_flat,
    output logic                           mat_valid,
    output logic                           vec_valid,
    output logic                           start,
    output logic                           err,
    output logic [1:0]                     err_code
);
    localparam int NB   = BITS / 8;
    localparam int NM   = MAT_R * MAT_C;
    localparam int NV   = TE * VEC_LEN;
    localparam int NMAX = NM > NV ? NM : NV;
    localparam int BW   = NB > 1 ? $clog2(NB) : 1;
    localparam int EW   = $clog2(NMAX + 1);
    localparam int IW   = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RX_MAT = 3'd1;
    localparam logic [2:0] RX_VEC = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] START  = 3'd4;
    localparam logic [1:0] E_CMD   = 2'b01;
    localparam logic [1:0] E_START = 2'b10;
    localparam logic [1:0] E_TO    = 2'b11;
    logic [2:0]         state;
    logic [EW-1:0]      elem;
    logic [BW-1:0]      bidx;
    logic [IW-1:0]      idle;
    logic [NM*BITS-1:0] mat_sh, mat_nx;
    logic [NV*BITS-1:0] vec_sh, vec_nx;
    logic               rx_mat, last;
    int                 pos;
    assign in_ready = state == IDLE || state == RX_MAT || state == RX_VEC;
    assign rx_mat   = state == RX_MAT;
    assign pos      = int'(elem) * BITS + int'(bidx) * 8;
    assign last     = bidx == BW'(NB - 1) && elem == (rx_mat ? EW'(NM - 1) : EW'(NV - 1));
    // Shadow with the incoming byte merged, so the final byte can commit in the same edge
    always_comb begin
        mat_nx = mat_sh;
        vec_nx = vec_sh;
        if (state == RX_MAT) mat_nx[pos +: 8] = in_data;
        if (state == RX_VEC) vec_nx[pos +: 8] = in_data;
    end
    // Frame FSM: command decode, payload capture, commit, start and error pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            elem      <= '0;
            bidx      <= '0;
            idle      <= '0;
            mat_sh    <= '0;
            vec_sh    <= '0;
            mat_flat  <= '0;
            vecs_flat <= '0;
            mat_valid <= 1'b0;
            vec_valid <= 1'b0;
            start     <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            start <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    elem <= '0;
                    bidx <= '0;
                    idle <= '0;
                    if (in_data == 8'hA1) state <= RX_MAT;
                    else if (in_data == 8'hA2) state <= RX_VEC;
                    else if (in_data == 8'hA3) begin
                        state <= START;
                        start <= mat_valid && vec_valid;
                        if (!(mat_valid && vec_valid)) begin
                            err      <= 1'b1;
                            err_code <= E_START;
                        end
                    end else begin
                        err      <= 1'b1;
                        err_code <= E_CMD;
                    end
                end
                RX_MAT, RX_VEC: begin
                    if (idle == IW'(TIMEOUT)) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        err_code <= E_TO;
                        mat_sh   <= '0;
                        vec_sh   <= '0;
                    end else if (in_valid) begin
                        idle <= '0;
                        if (bidx == BW'(NB - 1)) begin
                            bidx <= '0;
                            elem <= elem + EW'(1);
                        end else bidx <= bidx + BW'(1);
                        if (rx_mat) mat_sh <= mat_nx;
                        else vec_sh <= vec_nx;
                        if (last) begin
                            state <= COMMIT;
                            if (rx_mat) begin
                                mat_flat  <= mat_nx;
                                mat_valid <= 1'b1;
                            end else begin
                                vecs_flat <= vec_nx;
                                vec_valid <= 1'b1;
                            end
                        end
                    end else idle <= idle + IW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qwac_loader.sv
// tb_qwac_loader: directed checks of framing, commit latency, start, errors and timeout
module tb_qwac_loader;
    logic         clock = 0;
    logic         reset = 1;
    logic [7:0]   in_data = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [511:0] mat_flat;
    logic [127:0] vecs_flat;
    logic         mat_valid, vec_valid, start, err;
    logic [1:0]   err_code;
    int           checks = 0;
    int           errors = 0;
    logic [511:0] exp_m;
    logic [127:0] exp_v;
    int           cnt;

    qwac_loader dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mat_flat(mat_flat), .vecs_flat(vecs_flat), .mat_valid(mat_valid), .vec_valid(vec_valid),
        .start(start), .err(err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        in_data = b;
        in_valid = 1;
        while (!in_ready && w < 20) begin
            gap(1);
            w++;
        end
        if (w == 20) chk("ready_wait", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 0;
    endtask

    task automatic send_elem(input logic [15:0] v);
        send(v[7:0]);
        send(v[15:8]);
    endtask

    initial begin
        #23 reset = 0;
        gap(1);
        chk("rst_ready", in_ready, 1);
        chk("rst_mat", mat_flat, 0);
        chk("rst_vecs", vecs_flat, 0);
        chk("rst_valids", {mat_valid, vec_valid}, 0);
        chk("rst_pulses", {start, err, err_code}, 0);

        send(8'hA3);
        chk("nop_start", start, 0);
        chk("nop_err", err, 1);
        chk("nop_code", err_code, 2'b10);
        chk("nop_ready_low", in_ready, 0);
        gap(1);
        chk("nop_err_pulse", err, 0);
        chk("nop_ready_back", in_ready, 1);

        send(8'h55);
        chk("unk_err", err, 1);
        chk("unk_code", err_code, 2'b01);
        chk("unk_ready", in_ready, 1);

        send(8'hA2);
        for (int i = 1; i <= 7; i++) send_elem(16'(i));
        send(8'h08);
        chk("vec_not_early", vec_valid, 0);
        send(8'h00);
        chk("vec_valid", vec_valid, 1);
        chk("vec_ready_low", in_ready, 0);
        chk("vec_e0", vecs_flat[15:0], 16'd1);
        chk("vec_e7", vecs_flat[127:112], 16'd8);
        chk("vec_mat_valid", mat_valid, 0);
        gap(1);
        chk("vec_ready_back", in_ready, 1);

        send(8'hA1);
        for (int k = 0; k < 32; k++) send_elem(16'h0001);
        for (int k = 0; k < 32; k++) exp_m[k*16 +: 16] = 16'h0001;
        chk("mat_valid", mat_valid, 1);
        chk("mat_all_ones", mat_flat, exp_m);
        chk("mat_ready_low", in_ready, 0);

        send(8'hA3);
        chk("go_start", start, 1);
        chk("go_err", err, 0);
        chk("go_ready_low", in_ready, 0);
        gap(1);
        chk("go_start_pulse", start, 0);
        chk("go_ready_back", in_ready, 1);

        send(8'hA1);
        for (int k = 0; k < 10; k++) send(8'hFF);
        cnt = 0;
        while (!err && cnt < 1100) begin
            gap(1);
            cnt++;
        end
        chk("to_cycles", cnt, 1025);
        chk("to_code", err_code, 2'b11);
        chk("to_mat_kept", mat_flat, exp_m);
        chk("to_mat_valid", mat_valid, 1);
        gap(1);
        chk("to_ready", in_ready, 1);

        send(8'hA1);
        send_elem(16'hFFFF);
        exp_m[15:0] = 16'hFFFF;
        for (int k = 1; k < 32; k++) begin
            send_elem(16'(k));
            exp_m[k*16 +: 16] = 16'(k);
        end
        chk("reload_mat", mat_flat, exp_m);
        chk("reload_neg1", ($signed(mat_flat[15:0]) == -16'sd1), 1);
        chk("reload_e31", mat_flat[511:496], 16'd31);

        send(8'hA2);
        for (int i = 0; i < 8; i++) begin
            exp_v[i*16 +: 16] = 16'(16'h1234 * (i + 1));
            gap(i == 3 ? 1000 : $urandom_range(0, 20));
            send(exp_v[i*16 +: 8]);
            gap($urandom_range(0, 20));
            send(exp_v[i*16+8 +: 8]);
        end
        chk("gap_vecs", vecs_flat, exp_v);
        chk("gap_code_held", err_code, 2'b11);
        chk("gap_mat_kept", mat_flat, exp_m);

        send(8'hA1);
        for (int k = 0; k < 5; k++) send(8'h77);
        #3 reset = 1;
        #4 reset = 0;
        gap(1);
        chk("mid_rst_mat", mat_flat, 0);
        chk("mid_rst_valid", {mat_valid, vec_valid}, 0);
        chk("mid_rst_ready", in_ready, 1);
        send(8'h01);
        chk("mid_rst_cmd", err_code, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
